// File: rtl/register_file.sv
// 32 x 64-bit LEGv8 integer register file for the decode stage.
// Two combinational read ports with write-to-read bypass, one synchronous
// write port, and a bypass-free debug read port. XZR reads as zero and
// has no storage.

// One read port: array read followed by a single 2:1 bypass mux.
module register_file_rdport #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 31,
    parameter int NUM_REGS   = 2 ** ADDR_WIDTH
) (
    input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs,
    input  logic                                rst,
    input  logic [ADDR_WIDTH-1:0]               raddr,
    input  logic                                wen,
    input  logic [ADDR_WIDTH-1:0]               waddr,
    input  logic [DATA_WIDTH-1:0]               wdata,
    output logic [DATA_WIDTH-1:0]               rdata
);
    localparam logic [ADDR_WIDTH-1:0] ZR = ADDR_WIDTH'(ZERO_REG);

    logic                  hit;
    logic [DATA_WIDTH-1:0] arr;

    // The XZR slot of the array is tied to zero, so the array read already
    // yields 0 for index ZERO_REG; the hit qualifier keeps a write to XZR
    // from bypassing.
    assign arr = regs[raddr];
    assign hit = wen && (waddr == raddr) && (raddr != ZR);

    // Reset forces zero; otherwise bypass or stored value.
    always_comb begin
        rdata = '0;
        if (!rst)
            rdata = hit ? wdata : arr;
    end
endmodule

module register_file #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 31
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic [ADDR_WIDTH-1:0] READ_REG1,
    input  logic [ADDR_WIDTH-1:0] READ_REG2,
    input  logic [ADDR_WIDTH-1:0] WRITE_REG,
    input  logic [DATA_WIDTH-1:0] WRITE_DATA,
    input  logic                  REG_WRITE,
    input  logic [ADDR_WIDTH-1:0] DEBUG_REG,
    output logic [DATA_WIDTH-1:0] READ_DATA1,
    output logic [DATA_WIDTH-1:0] READ_DATA2,
    output logic [DATA_WIDTH-1:0] DEBUG_DATA
);
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    localparam int NUM_RP   = 2;

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
    logic [NUM_RP-1:0][ADDR_WIDTH-1:0]   raddr;
    logic [NUM_RP-1:0][DATA_WIDTH-1:0]   rdata;

    genvar i;
    generate
        for (i = 0; i < NUM_REGS; i++) begin : g_regs
            if (i == ZERO_REG) begin : g_zero
                assign regs[i] = '0;
            end else begin : g_store
                logic [DATA_WIDTH-1:0] q;
                // Async clear; capture writeback only outside reset.
                always_ff @(posedge CLOCK or posedge RESET) begin
                    if (RESET)
                        q <= '0;
                    else if (REG_WRITE && (WRITE_REG == ADDR_WIDTH'(i)))
                        q <= WRITE_DATA;
                end
                assign regs[i] = q;
            end
        end
    endgenerate

    assign raddr[0] = READ_REG1;
    assign raddr[1] = READ_REG2;

    generate
        for (i = 0; i < NUM_RP; i++) begin : g_rp
            register_file_rdport #(
                .DATA_WIDTH (DATA_WIDTH),
                .ADDR_WIDTH (ADDR_WIDTH),
                .ZERO_REG   (ZERO_REG),
                .NUM_REGS   (NUM_REGS)
            ) u_rp (
                .regs  (regs),
                .rst   (RESET),
                .raddr (raddr[i]),
                .wen   (REG_WRITE),
                .waddr (WRITE_REG),
                .wdata (WRITE_DATA),
                .rdata (rdata[i])
            );
        end
    endgenerate

    assign READ_DATA1 = rdata[0];
    assign READ_DATA2 = rdata[1];

    // Debug view shows stored contents only, never the in-flight write.
    always_comb begin
        DEBUG_DATA = '0;
        if (!RESET)
            DEBUG_DATA = regs[DEBUG_REG];
    end
endmodule
